// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// PC-source select encoding is {jump, branch}.
package fetch_controller_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  typedef enum logic [1:0] {
    S_INIT,
    S_REQ,
    S_STALL,
    S_ERR
  } state_t;

  function automatic logic [1:0] pulse_sel(
    input logic branch,
    input logic jump
  );
    if (jump)
      return PCSEL_JMP;
    else if (branch)
      return PCSEL_BR;
    else
      return PCSEL_SEQ;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-control bundle between hazard/branch logic,
// instruction memory, PC and the IF/ID register.
interface fetch_controller_if #(
  parameter int CNT_W = 16
);

  logic             branch;
  logic             jump;
  logic             hazard_stall;
  logic             imem_ack;
  logic             imem_req;
  logic             pc_write_enable;
  logic [1:0]       pc_src_sel;
  logic             ifid_write;
  logic             ifid_flush;
  logic             fetch_valid;
  logic             fetch_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  branch,
    input  jump,
    input  hazard_stall,
    input  imem_ack,
    output imem_req,
    output pc_write_enable,
    output pc_src_sel,
    output ifid_write,
    output ifid_flush,
    output fetch_valid,
    output fetch_timeout,
    output stall_cycles
  );

  modport slave (
    output branch,
    output jump,
    output hazard_stall,
    output imem_ack,
    input  imem_req,
    input  pc_write_enable,
    input  pc_src_sel,
    input  ifid_write,
    input  ifid_flush,
    input  fetch_valid,
    input  fetch_timeout,
    input  stall_cycles
  );

endinterface

// File: rtl/fetch_controller_redirect_latch.sv
// One-entry pending-redirect holder; a same-cycle pulse
// overrides the stored entry, jump beats branch.
module redirect_latch
  import fetch_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       branch,
  input  logic       jump,
  input  logic       load,
  input  logic       clear,
  output logic       valid,
  output logic [1:0] sel
);

  logic       pend_valid;
  logic [1:0] pend_sel;
  logic       pulse;

  assign pulse = branch | jump;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pend_valid <= 1'b0;
      pend_sel   <= PCSEL_SEQ;
    end else if (load && pulse) begin
      pend_valid <= 1'b1;
      pend_sel   <= pulse_sel(branch, jump);
    end
  end

  assign valid = pulse | pend_valid;
  assign sel   = pulse ? pulse_sel(branch, jump)
                       : pend_sel;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: req/ack to imem, PC load
// and source select, IF/ID write/flush, redirect holding.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_controller_if.master bus
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              timeout_q;

  logic       redir_valid;
  logic [1:0] redir_sel;
  logic       lat_load;
  logic       lat_clr;
  logic       wait_clr;
  logic       wait_inc;
  logic       timeout_set;

  logic       req;
  logic       pc_we;
  logic [1:0] src_sel;
  logic       ifid_w;
  logic       flush;
  logic       fvalid;

  redirect_latch u_latch (
    .clk    (clk),
    .rst    (rst),
    .branch (bus.branch),
    .jump   (bus.jump),
    .load   (lat_load),
    .clear  (lat_clr),
    .valid  (redir_valid),
    .sel    (redir_sel)
  );

  always_comb begin
    state_nx    = state;
    req         = 1'b0;
    pc_we       = 1'b0;
    src_sel     = PCSEL_SEQ;
    ifid_w      = 1'b0;
    flush       = 1'b0;
    fvalid      = 1'b0;
    lat_load    = 1'b0;
    lat_clr     = 1'b0;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      S_INIT: begin
        state_nx = S_REQ;
        wait_clr = 1'b1;
      end
      S_REQ: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          wait_clr = 1'b1;
          if (redir_valid) begin
            flush   = 1'b1;
            pc_we   = 1'b1;
            src_sel = redir_sel;
            lat_clr = 1'b1;
          end else if (bus.hazard_stall) begin
            state_nx = S_STALL;
          end else begin
            fvalid = 1'b1;
            ifid_w = 1'b1;
            pc_we  = 1'b1;
          end
        end else begin
          lat_load = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            timeout_set = 1'b1;
            state_nx    = S_ERR;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      S_STALL: begin
        req      = 1'b1;
        wait_clr = 1'b1;
        // A redirect overrides the stall without needing an ack.
        if (redir_valid) begin
          flush    = 1'b1;
          pc_we    = 1'b1;
          src_sel  = redir_sel;
          lat_clr  = 1'b1;
          state_nx = S_REQ;
        end else if (!bus.hazard_stall) begin
          state_nx = S_REQ;
          if (bus.imem_ack) begin
            fvalid = 1'b1;
            ifid_w = 1'b1;
            pc_we  = 1'b1;
          end
        end
      end
      S_ERR: begin
        state_nx = S_ERR;
      end
      default: begin
        state_nx = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (wait_clr)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_set)
        timeout_q <= 1'b1;
      if (!pc_we && (state == S_REQ || state == S_STALL)
          && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.imem_req        = req;
  assign bus.pc_write_enable = pc_we;
  assign bus.pc_src_sel      = src_sel;
  assign bus.ifid_write      = ifid_w;
  assign bus.ifid_flush      = flush;
  assign bus.fetch_valid     = fvalid;
  assign bus.fetch_timeout   = timeout_q;
  assign bus.stall_cycles    = stall_cnt;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: sequential fetch,
// redirects, hazard stalls, timeout and reset recovery.
module tb_fetch_controller;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  fetch_controller_if #(.CNT_W(16)) fif ();

  fetch_controller #(
    .ACK_TIMEOUT(16),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req, pc_we, sel[1:0], ifid_w, flush, fvalid}
  function automatic logic [6:0] outs();
    return {fif.imem_req, fif.pc_write_enable,
            fif.pc_src_sel, fif.ifid_write,
            fif.ifid_flush, fif.fetch_valid};
  endfunction

  task automatic drive(input logic b, input logic j,
                       input logic h, input logic a);
    @(negedge clk);
    fif.branch       = b;
    fif.jump         = j;
    fif.hazard_stall = h;
    fif.imem_ack     = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fif.branch       = 1'b0;
    fif.jump         = 1'b0;
    fif.hazard_stall = 1'b0;
    fif.imem_ack     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (outs() !== 7'b0_0_00_0_0_0)
      $display("FAIL reset_outs got %b want 0000000", outs());
    else pass_cnt++;
    total_cnt++;
    if ({fif.fetch_timeout, fif.stall_cycles} !== 17'd0)
      $display("FAIL reset_regs got to=%b sc=%0d want 0/0",
               fif.fetch_timeout, fif.stall_cycles);
    else pass_cnt++;
  endtask

  task automatic test_seq();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      if (fif.pc_write_enable === 1'b1) pulses++;
      total_cnt++;
      if (outs() !== 7'b1_1_00_1_0_1)
        $display("FAIL seq_fetch%0d got %b want 1100101",
                 i, outs());
      else pass_cnt++;
    end
    drive(0, 0, 0, 0);
    total_cnt++;
    if (pulses != 5 || fif.stall_cycles !== 16'd0)
      $display("FAIL seq_summary got pulses=%0d sc=%0d want 5/0",
               pulses, fif.stall_cycles);
    else pass_cnt++;
  endtask

  task automatic test_branch_wait();
    do_reset();
    drive(0, 0, 0, 0);
    total_cnt++;
    if (outs() !== 7'b1_0_00_0_0_0)
      $display("FAIL br_wait0 got %b want 1000000", outs());
    else pass_cnt++;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    total_cnt++;
    if (outs() !== 7'b1_1_01_0_1_0)
      $display("FAIL br_ack got %b want 1101010", outs());
    else pass_cnt++;
    drive(0, 0, 0, 1);
    total_cnt++;
    if (fif.stall_cycles !== 16'd3)
      $display("FAIL br_stalls got %0d want 3", fif.stall_cycles);
    else pass_cnt++;
    total_cnt++;
    if (outs() !== 7'b1_1_00_1_0_1)
      $display("FAIL br_latch_clr got %b want 1100101", outs());
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1);
      total_cnt++;
      if (outs() !== 7'b1_0_00_0_0_0)
        $display("FAIL hz_stall%0d got %b want 1000000",
                 i, outs());
      else pass_cnt++;
    end
    drive(0, 0, 0, 1);
    total_cnt++;
    if (outs() !== 7'b1_1_00_1_0_1)
      $display("FAIL hz_resume got %b want 1100101", outs());
    else pass_cnt++;
    drive(0, 0, 0, 1);
    total_cnt++;
    if (fif.stall_cycles !== 16'd2)
      $display("FAIL hz_stalls got %0d want 2", fif.stall_cycles);
    else pass_cnt++;
  endtask

  task automatic test_jump_branch();
    do_reset();
    drive(1, 1, 0, 1);
    total_cnt++;
    if (outs() !== 7'b1_1_10_0_1_0)
      $display("FAIL jb_tie got %b want 1110010", outs());
    else pass_cnt++;
  endtask

  task automatic test_stall_jump();
    do_reset();
    drive(0, 0, 1, 1);
    drive(0, 1, 1, 0);
    total_cnt++;
    if (outs() !== 7'b1_1_10_0_1_0)
      $display("FAIL sj_redirect got %b want 1110010", outs());
    else pass_cnt++;
    // Back in S_REQ a no-ack branch is held, not taken.
    drive(1, 0, 0, 0);
    total_cnt++;
    if (outs() !== 7'b1_0_00_0_0_0)
      $display("FAIL sj_in_req got %b want 1000000", outs());
    else pass_cnt++;
    drive(0, 0, 0, 1);
    total_cnt++;
    if (outs() !== 7'b1_1_01_0_1_0)
      $display("FAIL sj_latched got %b want 1101010", outs());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0);
    total_cnt++;
    if ({fif.fetch_timeout, fif.imem_req} !== 2'b01)
      $display("FAIL to_edge15 got to/req=%b want 01",
               {fif.fetch_timeout, fif.imem_req});
    else pass_cnt++;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    total_cnt++;
    if ({fif.fetch_timeout, outs()} !== 8'b1_0_0_00_0_0_0)
      $display("FAIL to_err got %b want 10000000",
               {fif.fetch_timeout, outs()});
    else pass_cnt++;
    drive(1, 1, 0, 1);
    total_cnt++;
    if ({fif.fetch_timeout, outs(), fif.stall_cycles}
        !== {8'b1_0_0_00_0_0_0, 16'd16})
      $display("FAIL to_sticky got to=%b outs=%b sc=%0d want 1/0/16",
               fif.fetch_timeout, outs(), fif.stall_cycles);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if ({fif.fetch_timeout, fif.imem_req} !== 2'b00)
      $display("FAIL to_reset got %b want 00",
               {fif.fetch_timeout, fif.imem_req});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    do_reset();
    total_cnt++;
    if (outs() !== 7'b0_0_00_0_0_0)
      $display("FAIL rm_init got %b want 0000000", outs());
    else pass_cnt++;
    drive(0, 0, 0, 1);
    total_cnt++;
    if (outs() !== 7'b1_1_00_1_0_1)
      $display("FAIL rm_latch_empty got %b want 1100101", outs());
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt         = 0;
    total_cnt        = 0;
    rst              = 1'b1;
    fif.branch       = 1'b0;
    fif.jump         = 1'b0;
    fif.hazard_stall = 1'b0;
    fif.imem_ack     = 1'b0;
    test_reset();
    test_seq();
    test_branch_wait();
    test_hazard();
    test_jump_branch();
    test_stall_jump();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
